// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a row of 7-segment digits.
// Each digit slot is SELECT (decoder settle) -> SHOW (digit lit) -> BLANK (all
// off, suppresses ghosting). New display values arrive over a valid/ready
// handshake and are staged in a pending buffer; they are committed only at a
// frame boundary or while idle, so a frame never mixes old and new digits.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SHOW_CYCLES  = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] in_data,
    input  logic [NUM_DIGITS-1:0]   in_dots,
    output logic [3:0]              hex_data,
    input  logic [7:0]              dec_segments,
    output logic [7:0]              segments,
    output logic [NUM_DIGITS-1:0]   digit_en
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_SHOW,
        S_BLANK
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [CNT_W-1:0]        cnt;

    logic [4*NUM_DIGITS-1:0] display_data;
    logic [NUM_DIGITS-1:0]   display_dots;
    logic [4*NUM_DIGITS-1:0] pending_data;
    logic [NUM_DIGITS-1:0]   pending_dots;
    logic                    pending_full;

    logic                    frame_end;
    logic                    commit;
    logic                    transfer;
    logic [IDX_W-1:0]        idx_wrap;
    logic [IDX_W-1:0]        nibble_idx;
    logic [4*NUM_DIGITS-1:0] view_data;
    logic [3:0]              next_nibble;
    logic [7:0]              lit_segments;
    logic [NUM_DIGITS-1:0]   one_hot;

    // Ready is pure register state, so in_valid never reaches in_ready combinationally.
    assign in_ready = !pending_full;
    assign transfer = in_valid && !pending_full;

    // Frame-boundary detection, commit decision and the next digit's nibble.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        frame_end    = 1'b0;
        commit       = 1'b0;
        idx_wrap     = '0;
        nibble_idx   = '0;
        view_data    = display_data;
        next_nibble  = '0;
        lit_segments = '0;
        one_hot      = '0;

        frame_end = (state == S_BLANK) && (cnt == BLANK_LAST) && (idx == IDX_LAST);
        // Commit in any idle cycle, or at the frame boundary while scanning continues.
        commit    = pending_full && ((state == S_IDLE) || (frame_end && enable));

        idx_wrap   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        nibble_idx = (state == S_BLANK) ? idx_wrap : '0;

        // Nibble for the next SELECT must come from the contents valid in that slot.
        view_data   = commit ? pending_data : display_data;
        next_nibble = view_data[{nibble_idx, 2'b00} +: 4];

        lit_segments = {dec_segments[7] | display_dots[idx], dec_segments[6:0]};
        one_hot      = {{(NUM_DIGITS - 1){1'b0}}, 1'b1} << idx;
    end

    // Pending buffer capture on handshake and commit into the live display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_data <= '0;
            display_dots <= '0;
            pending_data <= '0;
            pending_dots <= '0;
            pending_full <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            if (transfer) begin
                pending_data <= in_data;
                pending_dots <= in_dots;
                pending_full <= 1'b1;
            end else if (commit) begin
                display_data <= pending_data;
                display_dots <= pending_dots;
                pending_full <= 1'b0;
            end
        end
    end

    // Scan FSM with registered digit_en, segments and hex_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            cnt      <= '0;
            hex_data <= '0;
            digit_en <= '0;
            segments <= '0;
        end else if (!enable) begin
            // Dropping enable abandons the slot; the scan restarts at digit 0.
            state    <= S_IDLE;
            idx      <= '0;
            cnt      <= '0;
            digit_en <= '0;
            segments <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_SELECT;
                    idx      <= '0;
                    cnt      <= '0;
                    hex_data <= next_nibble;
                    digit_en <= '0;
                    segments <= '0;
                end

                // One cycle for the external decoder to settle on hex_data.
                S_SELECT: begin
                    state    <= S_SHOW;
                    cnt      <= '0;
                    digit_en <= one_hot;
                    segments <= lit_segments;
                end

                S_SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state    <= S_BLANK;
                        cnt      <= '0;
                        digit_en <= '0;
                        segments <= '0;
                    end else begin
                        cnt      <= cnt + CNT_W'(1);
                        segments <= lit_segments;
                    end
                end

                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state    <= S_SELECT;
                        cnt      <= '0;
                        idx      <= idx_wrap;
                        hex_data <= next_nibble;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    idx      <= '0;
                    cnt      <= '0;
                    digit_en <= '0;
                    segments <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl (4 digits, SHOW=3, BLANK=1). The reference model
// tracks the scan as a position within a 20-cycle frame and a staged pending
// value, and derives the expected outputs from that position arithmetically.
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int SLOT  = 5;
    localparam int FRAME = ND * SLOT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_data = '0;
    logic [3:0]    in_dots = '0;
    logic [3:0]    hex_data;
    logic [7:0]    dec_segments;
    logic [7:0]    segments;
    logic [3:0]    digit_en;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit            m_on;
    int            m_t;
    logic [15:0]   m_disp, m_pend;
    logic [3:0]    m_dots, m_pdots;
    bit            m_pfull;
    logic [3:0]    e_en;
    logic [7:0]    e_seg;
    logic          e_rdy;
    logic [3:0]    e_hex;
    bit            e_hex_chk;

    always #5 clk = ~clk;

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 8'h3F; 4'h1: seg7 = 8'h06; 4'h2: seg7 = 8'h5B; 4'h3: seg7 = 8'h4F;
            4'h4: seg7 = 8'h66; 4'h5: seg7 = 8'h6D; 4'h6: seg7 = 8'h7D; 4'h7: seg7 = 8'h07;
            4'h8: seg7 = 8'h7F; 4'h9: seg7 = 8'h6F; 4'hA: seg7 = 8'h77; 4'hB: seg7 = 8'h7C;
            4'hC: seg7 = 8'h39; 4'hD: seg7 = 8'h5E; 4'hE: seg7 = 8'h79; default: seg7 = 8'h71;
        endcase
    endfunction

    // Shared hex-to-segment decoder seen by the controller
    assign dec_segments = seg7(hex_data);

    seg_scan_ctrl #(.NUM_DIGITS(4), .SHOW_CYCLES(3), .BLANK_CYCLES(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_dots      (in_dots),
        .hex_data     (hex_data),
        .dec_segments (dec_segments),
        .segments     (segments),
        .digit_en     (digit_en)
    );

    task automatic model_reset();
        m_on = 0; m_t = 0; m_disp = '0; m_pend = '0; m_dots = '0; m_pdots = '0; m_pfull = 0;
        e_en = '0; e_seg = '0; e_rdy = 1'b1; e_hex = '0; e_hex_chk = 0;
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_step();
        int  pos, d, ph;
        bit  do_commit, do_xfer;
        pos       = m_t % FRAME;
        do_commit = m_pfull && (!m_on || (enable && pos == FRAME - 1));
        do_xfer   = in_valid && !m_pfull;
        if (do_commit) begin
            m_disp = m_pend; m_dots = m_pdots; m_pfull = 0;
        end
        if (do_xfer) begin
            m_pend = in_data; m_pdots = in_dots; m_pfull = 1;
        end
        if (!enable) begin
            m_on = 0; m_t = 0;
        end else if (!m_on) begin
            m_on = 1; m_t = 0;
        end else begin
            m_t++;
        end
        e_rdy = !m_pfull;
        e_en = '0; e_seg = '0; e_hex_chk = 0; e_hex = '0;
        if (m_on) begin
            pos = m_t % FRAME;
            d   = pos / SLOT;
            ph  = pos % SLOT;
            e_hex     = m_disp[4*d +: 4];
            e_hex_chk = (ph <= 3);
            if (ph >= 1 && ph <= 3) begin
                e_en  = 4'(1 << d);
                e_seg = seg7(e_hex) | (m_dots[d] ? 8'h80 : 8'h00);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0;
        model_reset();
        #12;
        checks++;
        if (digit_en !== 4'b0 || segments !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs digit_en=%b segments=%h expected 0000/00", digit_en, segments);
        end
        checks++;
        if (in_ready !== 1'b1 || hex_data !== 4'h0) begin
            failures++;
            $display("FAIL reset_ready in_ready=%b hex_data=%h expected 1/0", in_ready, hex_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (digit_en !== 4'b0 || segments !== 8'h00 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_after_reset digit_en=%b segments=%h in_ready=%b", digit_en, segments, in_ready);
        end
    endtask

    task automatic load_idle(input logic [15:0] data, input logic [3:0] dots);
        enable = 1'b0;
        tick(); tick();
        in_valid = 1'b1; in_data = data; in_dots = dots;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_scan_basic();
        load_idle(16'h12AF, 4'b0000);
        enable = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            checks++;
            if (digit_en !== e_en || segments !== e_seg || in_ready !== e_rdy) begin
                failures++;
                $display("FAIL scan_basic cyc=%0d got en=%b seg=%h rdy=%b exp en=%b seg=%h rdy=%b",
                         i, digit_en, segments, in_ready, e_en, e_seg, e_rdy);
            end
            if (e_hex_chk) begin
                checks++;
                if (hex_data !== e_hex) begin
                    failures++;
                    $display("FAIL scan_hex cyc=%0d got %h exp %h", i, hex_data, e_hex);
                end
            end
        end
    endtask

    task automatic test_midframe_write();
        int guard;
        guard = 0;
        while (!(m_on && (m_t % FRAME) == 7) && guard < 2 * FRAME) begin
            tick(); guard++;
        end
        in_valid = 1'b1; in_data = 16'h0000; in_dots = 4'b0000;
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_drop got in_ready=%b exp 0", in_ready);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            checks++;
            if (digit_en !== e_en || segments !== e_seg || in_ready !== e_rdy) begin
                failures++;
                $display("FAIL midframe_write cyc=%0d got en=%b seg=%h rdy=%b exp en=%b seg=%h rdy=%b",
                         i, digit_en, segments, in_ready, e_en, e_seg, e_rdy);
            end
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_return got in_ready=%b exp 1", in_ready);
        end
    endtask

    task automatic test_dots();
        logic [7:0] want;
        load_idle(16'h8888, 4'b0100);
        enable = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            want = (digit_en == 4'b0100) ? 8'hFF : ((digit_en != 4'b0000) ? 8'h7F : 8'h00);
            checks++;
            if (segments !== want || digit_en !== e_en) begin
                failures++;
                $display("FAIL dots cyc=%0d got en=%b seg=%h exp en=%b seg=%h", i, digit_en, segments, e_en, want);
            end
        end
    endtask

    task automatic test_enable_drop();
        int guard;
        guard = 0;
        while (!(m_on && (m_t % FRAME) == 12) && guard < 2 * FRAME) begin
            tick(); guard++;
        end
        checks++;
        if (digit_en !== 4'b0100) begin
            failures++;
            $display("FAIL pre_drop got digit_en=%b exp 0100", digit_en);
        end
        enable = 1'b0;
        tick();
        checks++;
        if (digit_en !== 4'b0000 || segments !== 8'h00) begin
            failures++;
            $display("FAIL enable_drop got en=%b seg=%h exp 0000/00", digit_en, segments);
        end
        tick(); tick();
        enable = 1'b1;
        tick();
        checks++;
        if (digit_en !== 4'b0000) begin
            failures++;
            $display("FAIL restart_select got digit_en=%b exp 0000", digit_en);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (digit_en !== 4'b0001 || segments !== e_seg) begin
                failures++;
                $display("FAIL restart_digit0 cyc=%0d got en=%b seg=%h exp en=0001 seg=%h", i, digit_en, segments, e_seg);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            enable   = ($urandom_range(0, 59) != 0);
            in_valid = ($urandom_range(0, 7) == 0);
            in_data  = 16'($urandom);
            in_dots  = 4'($urandom);
            tick();
            checks++;
            if (digit_en !== e_en || segments !== e_seg || in_ready !== e_rdy || !$onehot0(digit_en)) begin
                failures++;
                $display("FAIL random cyc=%0d got en=%b seg=%h rdy=%b exp en=%b seg=%h rdy=%b",
                         i, digit_en, segments, in_ready, e_en, e_seg, e_rdy);
            end
            if (e_hex_chk) begin
                checks++;
                if (hex_data !== e_hex) begin
                    failures++;
                    $display("FAIL random_hex cyc=%0d got %h exp %h", i, hex_data, e_hex);
                end
            end
        end
        in_valid = 1'b0;
        enable   = 1'b1;
    endtask

    task automatic test_reset_mid_show();
        int guard;
        guard = 0;
        while (!(m_on && (m_t % SLOT) == 2) && guard < 2 * FRAME) begin
            tick(); guard++;
        end
        if (m_pfull == 0) begin
            in_valid = 1'b1; in_data = 16'h5555; in_dots = 4'b1111;
        end
        tick();
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (digit_en !== 4'b0000 || segments !== 8'h00) begin
            failures++;
            $display("FAIL async_reset got en=%b seg=%h exp 0000/00", digit_en, segments);
        end
        checks++;
        if (in_ready !== 1'b1 || hex_data !== 4'h0) begin
            failures++;
            $display("FAIL async_reset_ready got rdy=%b hex=%h exp 1/0", in_ready, hex_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < FRAME + 2; i++) begin
            tick();
            checks++;
            if (digit_en !== e_en || segments !== e_seg || in_ready !== e_rdy) begin
                failures++;
                $display("FAIL post_reset cyc=%0d got en=%b seg=%h rdy=%b exp en=%b seg=%h rdy=%b",
                         i, digit_en, segments, in_ready, e_en, e_seg, e_rdy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_basic();
        test_midframe_write();
        test_dots();
        test_enable_drop();
        test_random();
        test_reset_mid_show();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter: NUM_DIGITS, default 4, number of multiplexed 7-segment digits (range 2..8).
REQ-002 Parameter: SHOW_CYCLES, default 1000, cycles a digit is lit per slot (>=1).
REQ-003 Parameter: BLANK_CYCLES, default 4, cycles all digits are off between slots, for ghosting suppression (>=1).
REQ-004 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: enable  input  1  scan enable; low forces IDLE.
REQ-007 Port: in_valid  input  1  new display value offered.
REQ-008 Port: in_ready  output  1  controller can accept a value.
REQ-009 Port: in_data  input  4*NUM_DIGITS  hex nibbles; digit i = in_data[4i+3:4i], digit 0 rightmost.
REQ-010 Port: in_dots  input  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-011 Port: hex_data  output  4  nibble to the shared hex-to-segment decoder.
REQ-012 Port: dec_segments  input  8  decoder output {dot,g,f,e,d,c,b,a}, valid one cycle after hex_data.
REQ-013 Port: segments  output  8  {dot,g,f,e,d,c,b,a} to the display, 1 = lit.
REQ-014 Port: digit_en  output  NUM_DIGITS  one-hot digit select, active-high.

Function
REQ-015 Registers: display (in_data, in_dots), pending (same width plus pending_full flag), digit index idx, slot counter cnt, state.
REQ-016 States: IDLE, SELECT, SHOW, BLANK.
REQ-017 IDLE: digit_en=0, segments=0, idx=0; go SELECT when enable=1.
REQ-018 SELECT: one cycle; hex_data = display nibble[idx]; digit_en=0; covers the one-cycle decoder latency; next SHOW.
REQ-019 SHOW: SHOW_CYCLES cycles; digit_en = one-hot(idx); segments = {dec_segments[7] | dots[idx], dec_segments[6:0]}; hex_data held; next BLANK.
REQ-020 BLANK: BLANK_CYCLES cycles; digit_en=0, segments=0; then idx advances and state goes SELECT.
REQ-021 Slot length = 1 + SHOW_CYCLES + BLANK_CYCLES cycles; frame = NUM_DIGITS slots.
REQ-022 idx wraps NUM_DIGITS-1 -> 0; the wrap point is the frame boundary.
REQ-023 Handshake: transfer when in_valid & in_ready; captured into pending, pending_full set next cycle.
REQ-024 in_ready = !pending_full (registered state, no combinational path from in_valid).
REQ-025 pending is copied to display and pending_full cleared at the frame boundary (last BLANK cycle of digit NUM_DIGITS-1) or in any IDLE cycle; a frame never mixes old and new values.
REQ-026 Transfer and frame-boundary commit in the same cycle cannot occur, since in_ready=0 while pending_full=1.
REQ-027 enable falling in any state: IDLE next cycle, cnt=0, idx=0; pending retained and committed in IDLE.
REQ-028 digit_en shall never have more than one bit set; digit_en and segments are registered outputs.

Reset
REQ-029 rst_n low: immediately state=IDLE, idx=0, cnt=0, display=0, dots=0, pending_full=0, in_ready=1, digit_en=0, segments=0, hex_data=0.
REQ-030 After rst_n rises, the first scan begins on the first edge with enable=1; reset mid-slot aborts the slot with no glitch on digit_en.

Verification (NUM_DIGITS=4, SHOW_CYCLES=3, BLANK_CYCLES=1)
REQ-031 Load in_data=16'h12AF, dots=0, enable=1 -> digit_en sequence 0001,0010,0100,1000 repeating, each on 3 cycles; segments during each = decoder codes for F,A,2,1.
REQ-032 Between any two lit slots -> exactly 2 cycles with digit_en=0 (BLANK + SELECT); slot period 5 cycles, frame 20 cycles.
REQ-033 Write 16'h0000 mid-frame -> in_ready drops the next cycle; current frame finishes showing 12AF; new value appears from digit 0 of the next frame; in_ready returns 1 after the commit.
REQ-034 in_dots=4'b0100 with value 16'h8888 -> segments=8'hFF only while digit_en=0100, else 8'h7F.
REQ-035 enable low during SHOW of digit 2 -> digit_en=0 next cycle; re-enable -> scan restarts at digit 0 after SELECT.
REQ-036 rst_n asserted mid-SHOW -> digit_en, segments = 0 without waiting for clk; display cleared; in_ready=1.
